// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer with validated preset load, terminal-count pulse
// and optional automatic reload of the last accepted preset.
module bcd_down_counter #(
  parameter int unsigned DIGITS      = 4,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                en,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  output logic [4*DIGITS-1:0] count,
  output logic                busy,
  output logic                done,
  output logic                load_err
);

  localparam int unsigned W = 4 * DIGITS;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         r_state, w_state_nxt;
  logic [W-1:0]   r_count, w_count_nxt;
  logic [W-1:0]   r_preset, w_preset_nxt;
  logic [W-1:0]   w_dec;
  logic           r_busy, w_busy_nxt;
  logic           r_done, w_done_nxt;
  logic           r_load_err, w_load_err_nxt;
  logic           w_load_ok;
  logic           w_load_zero;
  logic           w_at_one;
  logic           w_borrow;

  always_comb begin
    w_load_ok = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (load_value[4*i +: 4] > 4'd9) w_load_ok = 1'b0;
    end
  end

  // Ripple borrow: zero digits become 9 until the first nonzero digit absorbs it.
  always_comb begin
    w_dec    = r_count;
    w_borrow = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (w_borrow) begin
        if (r_count[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          w_borrow        = 1'b0;
        end
      end
    end
  end

  assign w_load_zero = (load_value == '0);
  assign w_at_one    = (r_count == W'(1));

  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_preset_nxt   = r_preset;
    w_done_nxt     = 1'b0;
    w_load_err_nxt = 1'b0;

    if (load && w_load_ok) begin
      w_count_nxt  = load_value;
      w_preset_nxt = load_value;
      if (w_load_zero) begin
        w_state_nxt = StDone;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = StRun;
      end
    end else begin
      // A rejected load only flags the error; normal operation continues.
      w_load_err_nxt = load;
      unique case (r_state)
        StIdle: ;
        StRun: begin
          if (en && (r_count != '0)) begin
            w_count_nxt = w_dec;
            if (w_at_one) begin
              w_state_nxt = StDone;
              w_done_nxt  = 1'b1;
            end
          end
        end
        StDone: begin
          if (AUTO_RELOAD) begin
            w_count_nxt = r_preset;
            if (r_preset == '0) begin
              w_done_nxt = 1'b1;
            end else begin
              w_state_nxt = StRun;
            end
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end

    w_busy_nxt = (w_state_nxt == StRun);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_count    <= '0;
      r_preset   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_preset   <= w_preset_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_load_err <= w_load_err_nxt;
    end
  end

  assign count    = r_count;
  assign busy     = r_busy;
  assign done     = r_done;
  assign load_err = r_load_err;

endmodule
